// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: operand/product valid-ready bundle for the iterative multiplier
interface seq_shift_add_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid, in_ready, in_signed;
   logic [WIDTH-1:0]     multiplicand, multiplier;
   logic                 out_valid, out_ready, busy;
   logic [2*WIDTH-1:0]   product;
   modport master (
      output in_valid, in_signed, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, busy
   );
   modport slave (
      input  in_valid, in_signed, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits per clock
module seq_shift_add_multiplier #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic                       clk,
   input logic                       rst,
   seq_shift_add_multiplier_if.slave mul_io
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d, prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               accept;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] pp;
   assign mul_io.in_ready  = state_q == S_IDLE || (state_q == S_DONE && mul_io.out_ready);
   assign mul_io.out_valid = state_q == S_DONE;
   assign mul_io.busy      = state_q == S_BUSY;
   assign mul_io.product   = prod_q;
   assign accept = mul_io.in_valid & mul_io.in_ready;
   assign a_mag  = (mul_io.in_signed & mul_io.multiplicand[WIDTH-1]) ? -mul_io.multiplicand : mul_io.multiplicand;
   assign b_mag  = (mul_io.in_signed & mul_io.multiplier[WIDTH-1]) ? -mul_io.multiplier : mul_io.multiplier;
   // a_q is pre-shifted each iteration, so the partial product needs no barrel shift
   assign pp = a_q * (2*WIDTH)'(b_q[BITS_PER_CYCLE-1:0]);
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      prod_d  = prod_q;
      if (accept) begin
         state_d = S_BUSY;
         a_d     = {{WIDTH{1'b0}}, a_mag};
         b_d     = b_mag;
         neg_d   = mul_io.in_signed & (mul_io.multiplicand[WIDTH-1] ^ mul_io.multiplier[WIDTH-1]);
         acc_d   = '0;
         cnt_d   = '0;
      end else if (state_q == S_BUSY) begin
         if (cnt_q == CW'(N)) begin
            state_d = S_DONE;
            prod_d  = neg_q ? -acc_q : acc_q;
         end else begin
            acc_d = acc_q + pp;
            a_d   = a_q << BITS_PER_CYCLE;
            b_d   = b_q >> BITS_PER_CYCLE;
            cnt_d = cnt_q + 1'b1;
         end
      end else if (state_q == S_DONE && mul_io.out_ready) begin
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         prod_q  <= prod_d;
      end
   end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed vectors on an 8x1 instance, random model compare on an 8x4 instance
module tb_seq_shift_add_multiplier;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   seq_shift_add_multiplier_if #(.WIDTH(8)) m1 ();
   seq_shift_add_multiplier_if #(.WIDTH(8)) m4 ();
   seq_shift_add_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .mul_io(m1));
   seq_shift_add_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .mul_io(m4));
   typedef struct {
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;
   vec_t vecs[12];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic op1(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat, output logic ow);
      int n = 0;
      m1.out_ready = 1'b1;
      while (!m1.in_ready && n < 50) begin tick(); n++; end
      m1.in_valid = 1'b1; m1.in_signed = s; m1.multiplicand = a; m1.multiplier = b;
      tick();
      m1.in_valid = 1'b0; m1.in_signed = ~s; m1.multiplicand = ~a; m1.multiplier = b ^ 8'h5A;
      lat = 0;
      do begin tick(); lat++; end while (!m1.out_valid && lat < 40);
      p = m1.product;
      tick();
      ow = m1.out_valid;
   endtask
   task automatic op4(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
      int n = 0;
      m4.out_ready = 1'b1;
      while (!m4.in_ready && n < 50) begin tick(); n++; end
      m4.in_valid = 1'b1; m4.in_signed = s; m4.multiplicand = a; m4.multiplier = b;
      tick();
      m4.in_valid = 1'b0; m4.in_signed = ~s; m4.multiplicand = ~a; m4.multiplier = ~b;
      lat = 0;
      do begin tick(); lat++; end while (!m4.out_valid && lat < 40);
      p = m4.product;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      logic [15:0] p, exp;
      logic        ow, bad, s;
      logic [7:0]  a, b;
      int          lat, idx, got, cyc, acc_cyc[3];
      logic [7:0]  qa[3], qb[3];
      logic        qs[3];
      logic [15:0] qp[3];
      vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
      vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vecs[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
      vecs[3]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
      vecs[4]  = '{1'b0, 8'h00, 8'h5A, 16'h0000};
      vecs[5]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
      vecs[6]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
      vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
      vecs[8]  = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
      vecs[9]  = '{1'b1, 8'h05, 8'hF9, 16'hFFDD};
      vecs[10] = '{1'b0, 8'h05, 8'h07, 16'h0023};
      vecs[11] = '{1'b1, 8'h01, 8'h00, 16'h0000};
      m1.in_valid = 0; m1.in_signed = 0; m1.multiplicand = 0; m1.multiplier = 0; m1.out_ready = 1;
      m4.in_valid = 0; m4.in_signed = 0; m4.multiplicand = 0; m4.multiplier = 0; m4.out_ready = 1;
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", m1.out_valid, 0);
      chk("rst_product", m1.product, 0);
      chk("rst_busy", m1.busy, 0);
      chk("rst_out_valid4", m4.out_valid, 0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_in_ready", m1.in_ready, 1);
      chk("rst_in_ready4", m4.in_ready, 1);
      foreach (vecs[i]) begin
         op1(vecs[i].s, vecs[i].a, vecs[i].b, p, lat, ow);
         chk($sformatf("vec%0d_product", i), p, vecs[i].p);
         chk($sformatf("vec%0d_latency", i), lat, 9);
         chk($sformatf("vec%0d_ov_width", i), ow, 0);
      end
      // stall in DONE for 20 cycles while a new operand pair is offered
      m1.out_ready = 1'b0; m1.in_valid = 1'b1; m1.in_signed = 0; m1.multiplicand = 8'h12; m1.multiplier = 8'h34;
      tick();
      m1.multiplicand = 8'hFF; m1.multiplier = 8'hFF; m1.in_signed = 1;
      chk("stall_busy", m1.busy, 1);
      chk("stall_busy_in_ready", m1.in_ready, 0);
      lat = 0;
      do begin tick(); lat++; end while (!m1.out_valid && lat < 40);
      chk("stall_latency", lat, 9);
      chk("stall_product", m1.product, 16'h03A8);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (m1.out_valid !== 1'b1 || m1.product !== 16'h03A8 || m1.in_ready !== 1'b0 || m1.busy !== 1'b0) bad = 1;
         tick();
      end
      chk("stall_hold", bad, 0);
      m1.in_valid = 1'b0; m1.out_ready = 1'b1;
      tick();
      chk("stall_release_ov", m1.out_valid, 0);
      chk("stall_release_busy", m1.busy, 0);
      // back-to-back: in_valid held while three ops are queued
      qs = '{1'b0, 1'b1, 1'b0};
      qa = '{8'h03, 8'hFE, 8'hAA};
      qb = '{8'h04, 8'h03, 8'h55};
      qp = '{16'h000C, 16'hFFFA, 16'h3872};
      idx = 0; got = 0; cyc = 0;
      m1.in_valid = 1; m1.in_signed = qs[0]; m1.multiplicand = qa[0]; m1.multiplier = qb[0];
      while (cyc < 200 && got < 3) begin
         bad = m1.in_valid & m1.in_ready;
         tick();
         cyc++;
         if (bad) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 3) begin
               m1.in_signed = qs[idx]; m1.multiplicand = qa[idx]; m1.multiplier = qb[idx];
            end else m1.in_valid = 0;
         end
         if (m1.out_valid) begin
            chk($sformatf("b2b%0d_product", got), m1.product, qp[got]);
            chk($sformatf("b2b%0d_latency", got), cyc - acc_cyc[got], 9);
            got++;
         end
      end
      chk("b2b_count", got, 3);
      m1.in_valid = 0;
      tick();
      // reset three cycles after accept
      m1.in_valid = 1; m1.in_signed = 0; m1.multiplicand = 8'h09; m1.multiplier = 8'h09;
      tick();
      m1.in_valid = 0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("midbusy_rst_ov", m1.out_valid, 0);
      chk("midbusy_rst_busy", m1.busy, 0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("midbusy_in_ready", m1.in_ready, 1);
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (m1.out_valid !== 1'b0 || m1.busy !== 1'b0) bad = 1;
         tick();
      end
      chk("midbusy_no_pulse", bad, 0);
      op1(1'b0, 8'h05, 8'h07, p, lat, ow);
      chk("post_rst_product", p, 16'h0023);
      chk("post_rst_latency", lat, 9);
      // reset while a result is held in DONE
      m1.out_ready = 0; m1.in_valid = 1; m1.in_signed = 0; m1.multiplicand = 8'h02; m1.multiplier = 8'h03;
      tick();
      m1.in_valid = 0;
      for (int i = 0; i < 12; i++) tick();
      chk("middone_held", m1.out_valid, 1);
      rst = 1'b1;
      #1;
      chk("middone_rst_ov", m1.out_valid, 0);
      tick();
      rst = 1'b0;
      m1.out_ready = 1;
      tick();
      chk("middone_in_ready", m1.in_ready, 1);
      // four bits per cycle against a behavioural product
      for (int i = 0; i < 1000; i++) begin
         s = 1'($urandom_range(0, 1));
         a = 8'($urandom);
         b = 8'($urandom);
         if (i == 0) begin s = 1; a = 8'h80; b = 8'h80; end
         if (i == 1) begin s = 0; a = 8'hFF; b = 8'hFF; end
         if (s) exp = $signed(a) * $signed(b);
         else   exp = a * b;
         op4(s, a, b, p, lat);
         chk($sformatf("r4_%0d_product s=%0d a=%0h b=%0h", i, s, a, b), p, exp);
         chk($sformatf("r4_%0d_latency", i), lat, 3);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
